// File: rtl/map_server.sv
`default_nettype none
// ============================================================================
// Module      : map_server
// Description : Tile map for a 40x30 playfield with 2-bit cells
//               (0 empty, 1 brick, 2 steel). A two-state FSM (LOAD/SERVE)
//               builds the default map one row per cycle. A VGA read port
//               answers o_is_wall with one cycle of latency. A valid/ready
//               game-logic port returns the cell kind and optionally
//               destroys bricks.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   i_request_x/i_request_y  : VGA lookup coordinates (6 bits each)
//   o_is_wall                : cell != empty for the previous-cycle lookup
//   i_reload                 : one-cycle pulse, rebuilds the default map
//   i_req_valid/x/y/hit      : game-logic query; hit requests damage
//   o_req_ready              : high while in SERVE
//   o_rsp_valid/o_rsp_kind   : one-cycle response carrying the pre-damage kind
//   o_loading                : high while in LOAD
//   o_brick_count            : number of brick cells currently in the map
// Configuration
//   DESTRUCTIBLE_WALL_EN     : when defined, hits on brick cells clear them
// ============================================================================
module map_server (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  i_request_x,
    input  logic [5:0]  i_request_y,
    output logic        o_is_wall,
    input  logic        i_reload,
    input  logic        i_req_valid,
    input  logic [5:0]  i_req_x,
    input  logic [5:0]  i_req_y,
    input  logic        i_req_hit,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic [1:0]  o_rsp_kind,
    output logic        o_loading,
    output logic [10:0] o_brick_count
);

    localparam int          c_COLS     = 40;
    localparam int          c_ROWS     = 30;
    localparam logic [4:0]  c_LAST_ROW = 5'd29;
    localparam logic [10:0] c_ROW_BRICKS = 11'd6;  // bricks at x = 3,9,..,33

    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_row;
    logic [10:0] r_brick_count;
    logic        r_is_wall;
    logic        r_rsp_valid;
    logic [1:0]  r_rsp_kind;

    logic [1:0]  r_grid [0:c_ROWS-1][0:c_COLS-1];

    logic [1:0]  w_vga_cell;
    logic [1:0]  w_req_cell;
    logic [1:0]  w_row_data [0:c_COLS-1];
    logic        w_row_brick;
    logic        w_row_border;
    logic        w_accept;
    logic        w_load_wr;
    logic        w_damage;

    // Coordinates outside the playfield read as steel.
    always_comb begin
        w_vga_cell = 2'd2;
        if (i_request_x < 6'd40 && i_request_y < 6'd30)
            w_vga_cell = r_grid[i_request_y[4:0]][i_request_x];
    end

    always_comb begin
        w_req_cell = 2'd2;
        if (i_req_x < 6'd40 && i_req_y < 6'd30)
            w_req_cell = r_grid[i_req_y[4:0]][i_req_x];
    end

    // Default map contents for the row currently being loaded.
    always_comb begin
        w_row_border = (r_row == 5'd0) || (r_row == c_LAST_ROW);
        w_row_brick  = !w_row_border && ((r_row % 5'd6) != 5'd0);
        for (int x = 0; x < c_COLS; x++) begin
            w_row_data[x] = 2'd0;
            if (w_row_border || x == 0 || x == c_COLS - 1)
                w_row_data[x] = 2'd2;
            else if ((x % 6) == 3 && w_row_brick)
                w_row_data[x] = 2'd1;
        end
    end

    assign w_accept  = i_req_valid && (r_state == SERVE);
    assign w_load_wr = (r_state == LOAD) && !i_reload;

`ifdef DESTRUCTIBLE_WALL_EN
    // A kind of 1 implies an in-range coordinate, so no extra bounds check.
    assign w_damage = w_accept && i_req_hit && (w_req_cell == 2'd1);
`else
    logic w_unused_hit;
    assign w_unused_hit = i_req_hit;
    assign w_damage     = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= LOAD;
        else
            r_state <= w_state_next;
    end

    // FSM: next state. A reload during LOAD stays in LOAD (row restarts).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD:    if (!i_reload && r_row == c_LAST_ROW) w_state_next = SERVE;
            SERVE:   if (i_reload) w_state_next = LOAD;
            default: w_state_next = LOAD;
        endcase
    end

    // Row counter, brick counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row         <= 5'd0;
            r_brick_count <= 11'd0;
            r_is_wall     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_kind    <= 2'd0;
        end else begin
            r_is_wall   <= (w_vga_cell != 2'd0);
            r_rsp_valid <= w_accept;
            if (w_accept)
                r_rsp_kind <= w_req_cell;

            if (i_reload) begin
                r_row         <= 5'd0;
                r_brick_count <= 11'd0;
            end else if (r_state == LOAD) begin
                r_row         <= (r_row == c_LAST_ROW) ? 5'd0 : r_row + 5'd1;
                r_brick_count <= r_brick_count + (w_row_brick ? c_ROW_BRICKS : 11'd0);
            end else if (w_damage && r_brick_count != 11'd0) begin
                r_brick_count <= r_brick_count - 11'd1;
            end
        end
    end

    // Grid storage: whole-row writes in LOAD, single-cell clears in SERVE.
    // The VGA read above sees the pre-write contents in a collision cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_load_wr) begin
                for (int x = 0; x < c_COLS; x++)
                    r_grid[r_row][x] <= w_row_data[x];
            end else if (w_damage) begin
                r_grid[i_req_y[4:0]][i_req_x] <= 2'd0;
            end
        end
    end

    assign o_is_wall     = r_is_wall;
    assign o_req_ready   = (r_state == SERVE);
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_kind    = r_rsp_kind;
    assign o_loading     = (r_state == LOAD);
    assign o_brick_count = r_brick_count;

endmodule
`default_nettype wire

// File: tb/tb_map_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_server
// Description : Scoreboard bench for map_server. Stimulus tasks push the
//               expected VGA flag / response kind into queues; a monitor on
//               the falling edge pops and compares whenever an output is due.
//               Expectations follow DESTRUCTIBLE_WALL_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_server;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  i_request_x, i_request_y;
    logic        o_is_wall;
    logic        i_reload;
    logic        i_req_valid;
    logic [5:0]  i_req_x, i_req_y;
    logic        i_req_hit;
    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [1:0]  o_rsp_kind;
    logic        o_loading;
    logic [10:0] o_brick_count;

    int n_vec = 0;
    int n_err = 0;

    logic       q_wall [$];
    logic [1:0] q_kind [$];
    logic       vga_issue = 1'b0;
    logic       vga_due   = 1'b0;

`ifdef DESTRUCTIBLE_WALL_EN
    localparam bit c_DW = 1'b1;
`else
    localparam bit c_DW = 1'b0;
`endif

    always #5 clk = ~clk;

    map_server dut (
        .clk           (clk),
        .rst           (rst),
        .i_request_x   (i_request_x),
        .i_request_y   (i_request_y),
        .o_is_wall     (o_is_wall),
        .i_reload      (i_reload),
        .i_req_valid   (i_req_valid),
        .i_req_x       (i_req_x),
        .i_req_y       (i_req_y),
        .i_req_hit     (i_req_hit),
        .o_req_ready   (o_req_ready),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_kind    (o_rsp_kind),
        .o_loading     (o_loading),
        .o_brick_count (o_brick_count)
    );

    // The VGA answer is due one cycle after the request is sampled.
    always @(posedge clk) vga_due <= vga_issue;

    always @(negedge clk) begin
        logic       e_wall;
        logic [1:0] e_kind;
        if (vga_due) begin
            n_vec++;
            if (q_wall.size() == 0) begin
                n_err++;
                $display("FAIL vga_wall: got %0b with nothing expected", o_is_wall);
            end else begin
                e_wall = q_wall.pop_front();
                if (o_is_wall !== e_wall) begin
                    n_err++;
                    $display("FAIL vga_wall: got %0b want %0b", o_is_wall, e_wall);
                end
            end
        end
        if (o_rsp_valid === 1'b1) begin
            n_vec++;
            if (q_kind.size() == 0) begin
                n_err++;
                $display("FAIL rsp_kind: unexpected response kind %0d", o_rsp_kind);
            end else begin
                e_kind = q_kind.pop_front();
                if (o_rsp_kind !== e_kind) begin
                    n_err++;
                    $display("FAIL rsp_kind: got %0d want %0d", o_rsp_kind, e_kind);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        vga_issue   = 1'b0;
        i_req_valid = 1'b0;
        i_req_hit   = 1'b0;
        i_reload    = 1'b0;
    endtask

    task automatic vga(input logic [5:0] x, input logic [5:0] y, input logic e);
        i_request_x = x;
        i_request_y = y;
        q_wall.push_back(e);
        vga_issue = 1'b1;
        step();
    endtask

    task automatic req(input logic [5:0] x, input logic [5:0] y,
                       input logic hit, input logic [1:0] e);
        i_req_valid = 1'b1;
        i_req_x     = x;
        i_req_y     = y;
        i_req_hit   = hit;
        q_kind.push_back(e);
        step();
    endtask

    task automatic both(input logic [5:0] x, input logic [5:0] y, input logic hit,
                        input logic e_wall, input logic [1:0] e_kind);
        i_request_x = x;
        i_request_y = y;
        q_wall.push_back(e_wall);
        vga_issue   = 1'b1;
        i_req_valid = 1'b1;
        i_req_x     = x;
        i_req_y     = y;
        i_req_hit   = hit;
        q_kind.push_back(e_kind);
        step();
    endtask

    // Cycles spent with o_req_ready low, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!o_req_ready && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        i_request_x = '0; i_request_y = '0;
        i_reload = 1'b0; i_req_valid = 1'b0;
        i_req_x = '0; i_req_y = '0; i_req_hit = 1'b0;
        repeat (3) step();

        check("reset_is_wall",     int'(o_is_wall),     0);
        check("reset_req_ready",   int'(o_req_ready),   0);
        check("reset_rsp_valid",   int'(o_rsp_valid),   0);
        check("reset_rsp_kind",    int'(o_rsp_kind),    0);
        check("reset_loading",     int'(o_loading),     1);
        check("reset_brick_count", int'(o_brick_count), 0);

        // Initial build
        rst = 1'b0;
        n = 0;
        while (o_loading && n < 100) begin
            step();
            n++;
        end
        check("load_cycles",       n,                   30);
        check("load_brick_count",  int'(o_brick_count), 144);
        check("load_req_ready",    int'(o_req_ready),   1);

        // VGA lookups
        vga(6'd3,  6'd5,  1'b1);
        vga(6'd3,  6'd6,  1'b0);
        vga(6'd0,  6'd10, 1'b1);
        vga(6'd45, 6'd2,  1'b1);
        vga(6'd33, 6'd28, 1'b1);
        vga(6'd20, 6'd15, 1'b0);
        vga(6'd39, 6'd29, 1'b1);
        vga(6'd10, 6'd40, 1'b1);

        // Queries without damage effects
        req(6'd9,  6'd1,  1'b0, 2'd1);
        req(6'd0,  6'd0,  1'b1, 2'd2);
        check("steel_hit_count",   int'(o_brick_count), 144);
        req(6'd5,  6'd5,  1'b1, 2'd0);
        req(6'd50, 6'd50, 1'b1, 2'd2);
        check("empty_hit_count",   int'(o_brick_count), 144);

        // Brick damage
        req(6'd9,  6'd1,  1'b1, 2'd1);
        check("brick_hit_count",   int'(o_brick_count), c_DW ? 143 : 144);
        req(6'd9,  6'd1,  1'b0, c_DW ? 2'd0 : 2'd1);

        // Same-cycle VGA read and damage at one cell
        both(6'd15, 6'd2, 1'b1, 1'b1, 2'd1);
        check("collide_count",     int'(o_brick_count), c_DW ? 142 : 144);
        vga(6'd15, 6'd2, c_DW ? 1'b0 : 1'b1);

        // Accept followed by reload: the response must still arrive
        req(6'd21, 6'd7, 1'b1, 2'd1);
        check("pre_reload_count",  int'(o_brick_count), c_DW ? 141 : 144);
        i_reload = 1'b1;
        step();
        check("reload_ready",      int'(o_req_ready),   0);
        check("reload_loading",    int'(o_loading),     1);
        wait_ready(n);
        check("reload_cycles",     n,                   30);
        check("reload_count",      int'(o_brick_count), 144);
        req(6'd9,  6'd1,  1'b0, 2'd1);
        vga(6'd15, 6'd2,  1'b1);
        vga(6'd21, 6'd7,  1'b1);

        // Reload in the middle of LOAD restarts at row 0
        i_reload = 1'b1;
        step();
        repeat (12) begin
            i_req_valid = 1'b1;   // must not be accepted while loading
            i_req_x = 6'd3; i_req_y = 6'd1;
            step();
        end
        check("mid_load_loading",  int'(o_loading),     1);
        i_reload = 1'b1;
        step();
        wait_ready(n);
        check("restart_cycles",    n,                   30);
        check("restart_count",     int'(o_brick_count), 144);
        req(6'd3,  6'd1,  1'b0, 2'd1);

        repeat (3) step();
        check("rsp_queue_left",    q_kind.size(),       0);
        check("vga_queue_left",    q_wall.size(),       0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/map_server.md
MAP_SERVER -- requirements
Module: map_server

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock (25 MHz domain).
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port i_request_x, input, 6 bits: column requested by the VGA renderer.
REQ-004 SHALL have port i_request_y, input, 6 bits: row requested by the VGA renderer.
REQ-005 SHALL have port o_is_wall, output, 1 bit: wall flag answering the VGA request.
REQ-006 SHALL have port i_reload, input, 1 bit: single-cycle pulse that rebuilds the default map.
REQ-007 SHALL have ports i_req_valid, input, 1 bit; i_req_x, input, 6 bits; i_req_y, input, 6 bits; i_req_hit, input, 1 bit; these form the game-logic query and damage request.
REQ-008 SHALL have port o_req_ready, output, 1 bit: request accepted when both i_req_valid and o_req_ready are high.
REQ-009 SHALL have ports o_rsp_valid, output, 1 bit; o_rsp_kind, output, 2 bits; these carry the response.
REQ-010 SHALL have port o_loading, output, 1 bit: high while the map is being built.
REQ-011 SHALL have port o_brick_count, output, 11 bits: number of brick cells currently in the map.

Function
REQ-012 SHALL hold a 40x30 grid with 2-bit cells: 0 empty, 1 brick, 2 steel.
REQ-013 SHALL treat any coordinate with x>=40 or y>=30 as steel on reads, and SHALL ignore writes to such coordinates.
REQ-014 SHALL use an FSM with states LOAD and SERVE; reset and i_reload enter LOAD at row 0.
REQ-015 LOAD SHALL write one row per cycle, rows 0..29, so the map is built in 30 cycles, then enter SERVE.
REQ-016 The default map SHALL be: steel on the border (x=0, x=39, y=0, y=29); brick where x mod 6 = 3 and y mod 6 != 0 on interior cells; empty elsewhere. This gives 144 bricks.
REQ-017 VGA port: o_is_wall SHALL equal (cell != 0) for the request coordinates sampled one cycle earlier; it is valid in every state, and during LOAD it reads the partially built map.
REQ-018 o_req_ready SHALL be high exactly in SERVE.
REQ-019 For an accepted request, o_rsp_valid SHALL pulse high for exactly one cycle on the next cycle, and o_rsp_kind SHALL give the cell kind before any damage is applied.
REQ-020 An accepted request with i_req_hit=1 on a brick cell SHALL set that cell to empty and decrement o_brick_count in the same update; hits on steel or empty cells SHALL change nothing.
REQ-021 When a VGA read and a damage write target the same cell in the same cycle, the VGA read SHALL return the pre-write value.
REQ-022 If i_reload arrives in the cycle after an accept, the pending response SHALL still be delivered.
REQ-023 i_reload during LOAD SHALL restart LOAD at row 0.
REQ-024 o_brick_count SHALL increment for each brick written during LOAD; it SHALL never underflow.

Reset
REQ-025 On rst, the FSM SHALL enter LOAD at row 0.
REQ-026 On rst, outputs SHALL take these values: o_is_wall=0, o_req_ready=0, o_rsp_valid=0, o_rsp_kind=0, o_loading=1, o_brick_count=0.
REQ-027 Grid contents SHALL be undefined until LOAD completes, and the bench SHALL not check them before then.

Configuration
REQ-028 Macro DESTRUCTIBLE_WALL_EN defined: damage behaves as specified in REQ-020.
REQ-029 Macro DESTRUCTIBLE_WALL_EN undefined: i_req_hit SHALL be ignored, requests SHALL still be answered per REQ-019, o_brick_count SHALL stay constant after LOAD, and the grid SHALL be read-only in SERVE.

Verification
REQ-030 Release rst, idle 30 cycles -> o_loading falls after exactly 30 cycles, o_brick_count=144, o_req_ready=1.
REQ-031 VGA request (3,5) then (3,6) then (0,10) then (45,2) -> o_is_wall sequence 1,0,1,1, each one cycle after its request.
REQ-032 Hit (9,1) with DESTRUCTIBLE_WALL_EN defined -> o_rsp_kind=1 next cycle, o_brick_count=143; a repeat query of (9,1) -> o_rsp_kind=0.
REQ-033 Hit (0,0) -> o_rsp_kind=2, count unchanged; with the macro undefined, hit (9,1) -> o_rsp_kind=1 and count stays 144.
REQ-034 VGA request and damage at (15,2) in the same cycle -> o_is_wall=1; the following VGA read of (15,2) -> 0.
REQ-035 After damage, pulse i_reload -> o_req_ready=0 for 30 cycles, count returns to 144, (9,1) is brick again; pulse i_reload at LOAD row 12 -> LOAD restarts and lasts 30 cycles total.
